// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the single-cycle RISC core:
//   - instruction field bit positions
//   - opcode and ALU funct codes
//   - immediate sign/zero extension helpers
// No ports (package).
// -----------------------------------------------------------------------------
package risc_pkg;

   // Instruction field positions
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 23;
   localparam int RT_HI  = 22;
   localparam int RT_LO  = 20;
   localparam int RD_HI  = 19;
   localparam int RD_LO  = 17;
   localparam int FN_HI  = 3;
   localparam int FN_LO  = 0;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   // Opcodes (16..63 fall through to NOP behaviour)
   localparam logic [5:0] OP_NOP  = 6'd0;
   localparam logic [5:0] OP_ALU  = 6'd1;
   localparam logic [5:0] OP_ADDI = 6'd2;
   localparam logic [5:0] OP_SUBI = 6'd3;
   localparam logic [5:0] OP_ANDI = 6'd4;
   localparam logic [5:0] OP_ORI  = 6'd5;
   localparam logic [5:0] OP_XORI = 6'd6;
   localparam logic [5:0] OP_SLTI = 6'd7;
   localparam logic [5:0] OP_LD   = 6'd8;
   localparam logic [5:0] OP_ST   = 6'd9;
   localparam logic [5:0] OP_BR   = 6'd10;
   localparam logic [5:0] OP_BMI  = 6'd11;
   localparam logic [5:0] OP_BPL  = 6'd12;
   localparam logic [5:0] OP_BZ   = 6'd13;
   localparam logic [5:0] OP_MOVE = 6'd14;
   localparam logic [5:0] OP_HALT = 6'd15;

   // ALU funct codes (12..15 perform no register write)
   localparam logic [3:0] FN_ADD = 4'd0;
   localparam logic [3:0] FN_SUB = 4'd1;
   localparam logic [3:0] FN_AND = 4'd2;
   localparam logic [3:0] FN_OR  = 4'd3;
   localparam logic [3:0] FN_XOR = 4'd4;
   localparam logic [3:0] FN_NOT = 4'd5;
   localparam logic [3:0] FN_SLL = 4'd6;
   localparam logic [3:0] FN_SRL = 4'd7;
   localparam logic [3:0] FN_SRA = 4'd8;
   localparam logic [3:0] FN_SLT = 4'd9;
   localparam logic [3:0] FN_INC = 4'd10;
   localparam logic [3:0] FN_DEC = 4'd11;

   function automatic logic [31:0] sign_ext(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   function automatic logic [31:0] zero_ext(input logic [15:0] imm);
      return {16'd0, imm};
   endfunction

endpackage

// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
// Eight 32-bit registers R0..R7 (R0 is ordinary and writable), two
// combinational read ports and one write port.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (clears all registers)
//   we       in   write enable
//   wa       in   3-bit write address
//   wd       in   32-bit write data
//   ra, rb   in   3-bit read addresses
//   rdata_a  out  contents of register ra
//   rdata_b  out  contents of register rb
// -----------------------------------------------------------------------------
module register_bank (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [2:0]  wa,
   input  logic [31:0] wd,
   input  logic [2:0]  ra,
   input  logic [2:0]  rb,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b
);

   logic [31:0] q [8];
   logic [7:0]  wen;

   // One-hot write-enable decode.
   always_comb begin
      wen = 8'd0;
      if (we) begin
         wen = 8'd1 << wa;
      end else begin
         wen = 8'd0;
      end
   end

   register_cell R0 (.clk(clk), .rst(rst), .we(wen[0]), .d(wd), .q(q[0]));
   register_cell R1 (.clk(clk), .rst(rst), .we(wen[1]), .d(wd), .q(q[1]));
   register_cell R2 (.clk(clk), .rst(rst), .we(wen[2]), .d(wd), .q(q[2]));
   register_cell R3 (.clk(clk), .rst(rst), .we(wen[3]), .d(wd), .q(q[3]));
   register_cell R4 (.clk(clk), .rst(rst), .we(wen[4]), .d(wd), .q(q[4]));
   register_cell R5 (.clk(clk), .rst(rst), .we(wen[5]), .d(wd), .q(q[5]));
   register_cell R6 (.clk(clk), .rst(rst), .we(wen[6]), .d(wd), .q(q[6]));
   register_cell R7 (.clk(clk), .rst(rst), .we(wen[7]), .d(wd), .q(q[7]));

   assign rdata_a = q[ra];
   assign rdata_b = q[rb];

endmodule

// File: rtl/register_cell.sv
// -----------------------------------------------------------------------------
// register_cell
// One 32-bit architectural register with write enable and synchronous reset.
// Powers up to zero without reset.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset (clears data)
//   we   in   write enable
//   d    in   32-bit write data
//   q    out  32-bit current contents
// -----------------------------------------------------------------------------
module register_cell (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [31:0] d,
   output logic [31:0] q
);

   logic [31:0] data = 32'd0;

   // Register storage: reset wins over write.
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= 32'd0;
      end else if (we) begin
         data <= d;
      end else begin
         data <= data;
      end
   end

   assign q = data;

endmodule

// File: rtl/risc_cpu.sv
// -----------------------------------------------------------------------------
// risc_cpu
// Single-cycle 32-bit RISC processor: one instruction per rising edge,
// internal instruction ROM and data RAM, eight-register bank (instance RB).
// Parameters:
//   IMEM_FILE  name of the program image for instruction memory
//   MEM_DEPTH  words in each of instruction and data memory
// Ports:
//   clk          in  clock, all state updates on the rising edge
//   rst          in  synchronous active-high reset (PC, registers, halted flag)
//   halt_button  in  freezes all architectural state while high
// -----------------------------------------------------------------------------
module risc_cpu
   import risc_pkg::*;
#(
   parameter string IMEM_FILE = "program.hex",
   parameter int    MEM_DEPTH = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic halt_button
);

   localparam int AW = $clog2(MEM_DEPTH);

   logic [31:0] PC = 32'd0;
   logic        halted = 1'b0;
   logic [31:0] imem [MEM_DEPTH] = '{default: 32'd0};
   logic [31:0] dmem [MEM_DEPTH] = '{default: 32'd0};

   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [2:0]  rs, rt, rd;
   logic [3:0]  funct;
   logic [15:0] imm;
   logic [31:0] imm_ext;
   logic [31:0] rs_val, rt_val;
   logic [31:0] eff_addr;
   logic [AW-1:0] iaddr, daddr;
   logic [31:0] alu_out;
   logic        alu_valid;
   logic        reg_we, mem_we, take_branch, halt_op;
   logic [2:0]  reg_wa;
   logic [31:0] reg_wd;
   logic [31:0] pc_plus1, next_pc;
   logic        run;
   logic        unused_bits;

   assign iaddr   = AW'(PC % 32'(MEM_DEPTH));
   assign instr   = imem[iaddr];
   assign opcode  = instr[OPC_HI:OPC_LO];
   assign rs      = instr[RS_HI:RS_LO];
   assign rt      = instr[RT_HI:RT_LO];
   assign rd      = instr[RD_HI:RD_LO];
   assign funct   = instr[FN_HI:FN_LO];
   assign imm     = instr[IMM_HI:IMM_LO];
   assign unused_bits = instr[16];

   // Logical immediates are zero-extended; everything else sign-extended.
   assign imm_ext = (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
                    ? zero_ext(imm) : sign_ext(imm);

   assign eff_addr = rs_val + imm_ext;
   assign daddr    = AW'(eff_addr % 32'(MEM_DEPTH));

   // State may only change when neither halted nor frozen by the button.
   assign run = !halted && !halt_button;

   register_bank RB (
      .clk     (clk),
      .rst     (rst),
      .we      (reg_we && run),
      .wa      (reg_wa),
      .wd      (reg_wd),
      .ra      (rs),
      .rb      (rt),
      .rdata_a (rs_val),
      .rdata_b (rt_val)
   );

   // Register-register ALU; funct 12..15 flag no write.
   always_comb begin
      alu_out   = 32'd0;
      alu_valid = 1'b1;
      case (funct)
         FN_ADD:  alu_out = rs_val + rt_val;
         FN_SUB:  alu_out = rs_val - rt_val;
         FN_AND:  alu_out = rs_val & rt_val;
         FN_OR:   alu_out = rs_val | rt_val;
         FN_XOR:  alu_out = rs_val ^ rt_val;
         FN_NOT:  alu_out = ~rs_val;
         FN_SLL:  alu_out = rs_val << rt_val[4:0];
         FN_SRL:  alu_out = rs_val >> rt_val[4:0];
         FN_SRA:  alu_out = $unsigned($signed(rs_val) >>> rt_val[4:0]);
         FN_SLT:  alu_out = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
         FN_INC:  alu_out = rs_val + 32'd1;
         FN_DEC:  alu_out = rs_val - 32'd1;
         default: alu_valid = 1'b0;
      endcase
   end

   // Instruction decode: write-back selection, store, branch and halt.
   always_comb begin
      reg_we      = 1'b0;
      reg_wa      = rt;
      reg_wd      = 32'd0;
      mem_we      = 1'b0;
      take_branch = 1'b0;
      halt_op     = 1'b0;
      case (opcode)
         OP_NOP:  reg_we = 1'b0;
         OP_ALU: begin
            reg_we = alu_valid;
            reg_wa = rd;
            reg_wd = alu_out;
         end
         OP_ADDI: begin reg_we = 1'b1; reg_wd = rs_val + imm_ext; end
         OP_SUBI: begin reg_we = 1'b1; reg_wd = rs_val - imm_ext; end
         OP_ANDI: begin reg_we = 1'b1; reg_wd = rs_val & imm_ext; end
         OP_ORI:  begin reg_we = 1'b1; reg_wd = rs_val | imm_ext; end
         OP_XORI: begin reg_we = 1'b1; reg_wd = rs_val ^ imm_ext; end
         OP_SLTI: begin
            reg_we = 1'b1;
            reg_wd = ($signed(rs_val) < $signed(imm_ext)) ? 32'd1 : 32'd0;
         end
         OP_LD:   begin reg_we = 1'b1; reg_wd = dmem[daddr]; end
         OP_ST:   mem_we = 1'b1;
         OP_BR:   take_branch = 1'b1;
         OP_BMI:  take_branch = rs_val[31];
         OP_BPL:  take_branch = !rs_val[31] && (rs_val != 32'd0);
         OP_BZ:   take_branch = (rs_val == 32'd0);
         OP_MOVE: begin reg_we = 1'b1; reg_wd = rs_val; end
         OP_HALT: halt_op = 1'b1;
         default: reg_we = 1'b0;
      endcase
   end

   assign pc_plus1 = PC + 32'd1;
   assign next_pc  = take_branch ? (pc_plus1 + imm_ext) : pc_plus1;

   // PC and sticky halted flag: reset > halted/button > execute.
   always_ff @(posedge clk) begin
      if (rst) begin
         PC     <= 32'd0;
         halted <= 1'b0;
      end else if (!run) begin
         PC     <= PC;
         halted <= halted;
      end else if (halt_op) begin
         PC     <= PC;
         halted <= 1'b1;
      end else begin
         PC     <= next_pc;
         halted <= 1'b0;
      end
   end

   // Data RAM write port; reset leaves memory contents untouched.
   always_ff @(posedge clk) begin
      if (!rst && run && mem_we) begin
         dmem[daddr] <= rt_val;
      end
   end

endmodule

// File: tb/tb_risc_cpu.sv
// -----------------------------------------------------------------------------
// tb_risc_cpu
// Directed program walk-through followed by a random program, with every
// edge compared against an instruction-level reference interpreter.
// -----------------------------------------------------------------------------
module tb_risc_cpu;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic halt_button = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_imem [256];
   logic [31:0] m_dmem [256];
   logic [31:0] m_regs [8];
   logic [31:0] m_pc;
   logic        m_halted;

   always #5 clk = ~clk;

   risc_cpu #(.IMEM_FILE(""), .MEM_DEPTH(256)) dut (
      .clk         (clk),
      .rst         (rst),
      .halt_button (halt_button)
   );

   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
      logic [31:0] w;
      w = 32'd0;
      w[31:26] = op[5:0];
      w[25:23] = rs[2:0];
      w[22:20] = rt[2:0];
      w[15:0]  = imm[15:0];
      return w;
   endfunction

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
      logic [31:0] w;
      w = 32'd0;
      w[31:26] = 6'd1;
      w[25:23] = rs[2:0];
      w[22:20] = rt[2:0];
      w[19:17] = rd[2:0];
      w[3:0]   = fn[3:0];
      return w;
   endfunction

   function automatic logic [31:0] dut_reg(input int i);
      case (i)
         0: return dut.RB.R0.data;
         1: return dut.RB.R1.data;
         2: return dut.RB.R2.data;
         3: return dut.RB.R3.data;
         4: return dut.RB.R4.data;
         5: return dut.RB.R5.data;
         6: return dut.RB.R6.data;
         7: return dut.RB.R7.data;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input int a, input logic [31:0] w);
      dut.imem[a] = w;
      m_imem[a]   = w;
   endtask

   // Reference interpreter: one architectural step per edge.
   task automatic model_step(input logic r, input logic hb);
      logic [31:0] w, a, b, sx, zx, res, nxt;
      int op, fn, rs, rt, rd;
      bit wr;
      if (r) begin
         m_pc = 32'd0;
         m_halted = 1'b0;
         for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
      end else if (!m_halted && !hb) begin
         w  = m_imem[m_pc % 256];
         op = int'(w[31:26]);
         rs = int'(w[25:23]);
         rt = int'(w[22:20]);
         rd = int'(w[19:17]);
         fn = int'(w[3:0]);
         a  = m_regs[rs];
         b  = m_regs[rt];
         sx = {{16{w[15]}}, w[15:0]};
         zx = {16'd0, w[15:0]};
         nxt = m_pc + 32'd1;
         res = 32'd0;
         wr  = 1'b1;
         case (op)
            1: begin
               case (fn)
                  0:  res = a + b;
                  1:  res = a - b;
                  2:  res = a & b;
                  3:  res = a | b;
                  4:  res = a ^ b;
                  5:  res = ~a;
                  6:  res = a << b[4:0];
                  7:  res = a >> b[4:0];
                  8:  res = $signed(a) >>> b[4:0];
                  9:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  10: res = a + 32'd1;
                  11: res = a - 32'd1;
                  default: wr = 1'b0;
               endcase
               if (wr) m_regs[rd] = res;
            end
            2:  m_regs[rt] = a + sx;
            3:  m_regs[rt] = a - sx;
            4:  m_regs[rt] = a & zx;
            5:  m_regs[rt] = a | zx;
            6:  m_regs[rt] = a ^ zx;
            7:  m_regs[rt] = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
            8:  m_regs[rt] = m_dmem[(a + sx) % 256];
            9:  m_dmem[(a + sx) % 256] = b;
            10: nxt = nxt + sx;
            11: if ($signed(a) < 32'sd0) nxt = nxt + sx;
            12: if ($signed(a) > 32'sd0) nxt = nxt + sx;
            13: if (a == 32'd0) nxt = nxt + sx;
            14: m_regs[rt] = a;
            15: begin m_halted = 1'b1; nxt = m_pc; end
            default: wr = 1'b0;
         endcase
         m_pc = nxt;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(rst, halt_button);
      #1;
      check("pc", dut.PC, m_pc);
      for (int i = 0; i < 8; i++) check($sformatf("r%0d", i), dut_reg(i), m_regs[i]);
   endtask

   function automatic logic [31:0] rand_instr();
      int op;
      logic [31:0] w;
      op = $urandom_range(0, 17);
      if (op == 15 && $urandom_range(0, 3) != 0) op = 1;
      if (op >= 16) op = $urandom_range(16, 63);
      w = $urandom;
      w[31:26] = op[5:0];
      if (op >= 10 && op <= 13) w[15:0] = 16'($urandom_range(0, 16)) - 16'd8;
      return w;
   endfunction

   initial begin
      m_pc = 32'd0;
      m_halted = 1'b0;
      for (int i = 0; i < 256; i++) begin m_imem[i] = 32'd0; m_dmem[i] = 32'd0; end
      for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
      #1;
      // Directed program
      load_word(0,  enc_i(2, 0, 1, 5));
      load_word(1,  enc_i(2, 0, 2, 7));
      load_word(2,  enc_r(1, 2, 3, 0));
      load_word(3,  enc_i(9, 0, 3, 10));
      load_word(4,  enc_i(13, 0, 0, 2));
      load_word(7,  enc_i(8, 0, 4, 10));
      load_word(8,  enc_i(3, 0, 5, 1));
      load_word(9,  enc_i(11, 5, 0, 1));
      load_word(10, enc_i(2, 0, 6, 99));
      load_word(11, enc_i(12, 0, 0, 5));
      load_word(12, enc_i(2, 0, 1, -8));
      load_word(13, enc_i(2, 0, 2, 1));
      load_word(14, enc_r(1, 2, 3, 8));
      load_word(15, enc_r(1, 2, 4, 7));
      load_word(16, enc_r(1, 2, 6, 6));
      load_word(17, enc_r(1, 2, 7, 9));
      load_word(18, enc_r(2, 0, 3, 10));
      load_word(19, enc_r(2, 0, 4, 11));
      load_word(20, enc_i(10, 0, 0, -1));

      check("pwr_pc", dut.PC, 32'd0);
      check("pwr_r1", dut_reg(1), 32'd0);
      tick(); check("addi_r1", dut_reg(1), 32'd5);
      tick(); check("addi_r2", dut_reg(2), 32'd7);
      tick(); check("add_r3", dut_reg(3), 32'd12); check("chain_pc", dut.PC, 32'd3);
      tick(); check("st_mem", dut.dmem[10], 32'd12);
      tick(); check("bz_pc", dut.PC, 32'd7);
      tick(); check("ld_r4", dut_reg(4), 32'd12); check("ld_pc", dut.PC, 32'd8);
      halt_button = 1'b1;
      repeat (3) tick();
      check("hbtn_pc", dut.PC, 32'd8); check("hbtn_r5", dut_reg(5), 32'd0);
      halt_button = 1'b0;
      tick(); check("subi_r5", dut_reg(5), 32'hFFFF_FFFF);
      tick(); check("bmi_pc", dut.PC, 32'd11);
      tick(); check("bpl_pc", dut.PC, 32'd12);
      tick(); check("neg8_r1", dut_reg(1), 32'hFFFF_FFF8);
      tick();
      tick(); check("sra_r3", dut_reg(3), 32'hFFFF_FFFC);
      tick(); check("srl_r4", dut_reg(4), 32'h7FFF_FFFC);
      tick(); check("sll_r6", dut_reg(6), 32'hFFFF_FFF0);
      tick(); check("slt_r7", dut_reg(7), 32'd1);
      tick(); check("inc_r3", dut_reg(3), 32'd2);
      tick(); check("dec_r4", dut_reg(4), 32'd0); check("pre_br_pc", dut.PC, 32'd20);
      tick(); tick(); check("br_loop_pc", dut.PC, 32'd20);
      load_word(20, enc_i(15, 0, 0, 0));
      tick();
      repeat (5) tick();
      check("halt_pc", dut.PC, 32'd20); check("halt_r7", dut_reg(7), 32'd1);
      rst = 1'b1;
      tick(); check("rst_pc", dut.PC, 32'd0); check("rst_r7", dut_reg(7), 32'd0);
      rst = 1'b0;
      tick(); check("restart_r1", dut_reg(1), 32'd5); check("restart_pc", dut.PC, 32'd1);
      check("rst_keeps_mem", dut.dmem[10], 32'd12);

      // Random program with random freezes and resets
      for (int a = 0; a < 256; a++) begin
         if (a < 8) load_word(a, enc_i(2, 0, a, int'($urandom)));
         else       load_word(a, rand_instr());
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (600) begin
         halt_button = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 79) == 0);
         tick();
      end
      rst = 1'b0;
      halt_button = 1'b0;
      for (int a = 0; a < 256; a++) check($sformatf("dmem%0d", a), dut.dmem[a], m_dmem[a]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
